// File: rtl/lz_matcher_if.sv
// lz_matcher_if: literal-in / token-out handshake bundle for lz_matcher.
// in_* carry 4-bit literals in; tok_* carry 5-bit symbols + 6 extra bits out.
interface lz_matcher_if;
  logic       in_vld;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_rdy;
  logic       tok_vld;
  logic [4:0] tok_data;
  logic [5:0] tok_ext;
  logic       tok_last;
  logic       tok_rdy;

  modport master (
    output in_vld, in_data, in_last, tok_rdy,
    input  in_rdy, tok_vld, tok_data, tok_ext, tok_last
  );

  modport slave (
    input  in_vld, in_data, in_last, tok_rdy,
    output in_rdy, tok_vld, tok_data, tok_ext, tok_last
  );
endinterface

// File: rtl/lz_matcher.sv
// lz_matcher: greedy LZ77 matcher over a WIN-deep shift-register history.
// Ports: clk, rst_n (async, active-low), bus (slave side of lz_matcher_if).
module lz_matcher #(
  parameter int WIN = 16
) (
  input logic         clk,
  input logic         rst_n,
  lz_matcher_if.slave bus
);
  localparam int IW = $clog2(WIN);
  localparam int FW = $clog2(WIN + 1);

  typedef enum logic [2:0] {
    ACCUM,
    EMIT_LEN,
    EMIT_DIST,
    EMIT_LIT,
    FLUSH_LAST
  } state_t;

  state_t         r_state;
  logic [3:0]     r_hist [WIN];
  logic [FW-1:0]  r_fill;
  logic [4:0]     r_len;
  logic [WIN-1:0] r_mask;
  logic           r_tok_vld;
  logic [4:0]     r_tok_data;
  logic [5:0]     r_tok_ext;
  logic           r_tok_last;
  logic [8:0]     r_dq;
  logic [1:0]     r_lit_idx;
  logic [1:0]     r_lit_cnt;
  logic           r_final;
  logic           r_pend;

  function automatic logic [IW-1:0] lowbit(
    input logic [WIN-1:0] v
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = WIN - 1; i >= 0; i--)
      if (v[i]) r = IW'(i);
    return r;
  endfunction

  logic           w_acc;
  logic [WIN-1:0] w_eq;
  logic [WIN-1:0] w_m;
  logic           w_hit;
  logic           w_max;
  logic [4:0]     w_nlen;
  logic [WIN-1:0] w_nmask;
  logic [3:0]     w_nhist [WIN];
  logic [3:0]     w_hv [WIN];

  assign w_acc = bus.in_vld && (r_state == ACCUM);

  always_comb begin
    w_eq = '0;
    for (int d = 0; d < WIN; d++)
      w_eq[d] = (bus.in_data == r_hist[d]) &&
                (d < int'(r_fill));
  end

  assign w_m   = (r_len == 5'd0) ? w_eq : (r_mask & w_eq);
  assign w_hit = |w_m;
  assign w_max = w_hit && (r_len == 5'd17);

  always_comb begin
    w_nlen  = 5'd1;
    w_nmask = w_eq;
    if (w_max) begin
      w_nlen  = 5'd0;
      w_nmask = '0;
    end else if (w_hit) begin
      w_nlen  = r_len + 5'd1;
      w_nmask = w_m;
    end
  end

  // Emission starting in ACCUM sees the post-shift window;
  // FLUSH_LAST sees the already-shifted registers.
  always_comb begin
    w_nhist[0] = bus.in_data;
    for (int i = 1; i < WIN; i++)
      w_nhist[i] = r_hist[i-1];
    for (int i = 0; i < WIN; i++)
      w_hv[i] = (r_state == ACCUM) ? w_nhist[i] : r_hist[i];
  end

  logic          w_st_go;
  logic          w_st_match;
  logic          w_st_final;
  logic          w_st_pend;
  logic [3:0]    w_st_lc;
  logic [IW-1:0] w_st_dq;
  logic [1:0]    w_st_idx;
  logic [1:0]    w_st_cnt;

  always_comb begin
    w_st_go    = 1'b0;
    w_st_match = 1'b0;
    w_st_final = 1'b0;
    w_st_pend  = 1'b0;
    w_st_lc    = '0;
    w_st_dq    = '0;
    w_st_idx   = '0;
    w_st_cnt   = '0;
    if (r_state == FLUSH_LAST) begin
      w_st_go    = 1'b1;
      w_st_match = (r_len >= 5'd3);
      w_st_lc    = r_len[3:0] - 4'd3;
      w_st_dq    = lowbit(r_mask);
      w_st_cnt   = r_len[1:0];
      w_st_idx   = r_len[1:0] - 2'd1;
      w_st_final = 1'b1;
    end else if (w_acc) begin
      if (w_max) begin
        w_st_go    = 1'b1;
        w_st_match = 1'b1;
        w_st_lc    = 4'd15;
        w_st_dq    = lowbit(w_m);
        w_st_final = bus.in_last;
      end else if (!w_hit && r_len >= 5'd3) begin
        w_st_go    = 1'b1;
        w_st_match = 1'b1;
        w_st_lc    = r_len[3:0] - 4'd3;
        w_st_dq    = lowbit(r_mask);
        w_st_pend  = bus.in_last;
      end else if (!w_hit && r_len != 5'd0) begin
        // old 1..2 symbol run sits one slot deeper after the shift
        w_st_go    = 1'b1;
        w_st_cnt   = r_len[1:0];
        w_st_idx   = r_len[1:0];
        w_st_pend  = bus.in_last;
      end else if (bus.in_last) begin
        w_st_go    = 1'b1;
        w_st_match = (w_nlen >= 5'd3);
        w_st_lc    = w_nlen[3:0] - 4'd3;
        w_st_dq    = lowbit(w_nmask);
        w_st_cnt   = w_nlen[1:0];
        w_st_idx   = w_nlen[1:0] - 2'd1;
        w_st_final = 1'b1;
      end
    end
  end

  logic [4:0] w_st_data;
  logic       w_st_last;
  logic       w_done;

  assign w_st_data = w_st_match ? {1'b1, w_st_lc}
                                : {1'b0, w_hv[IW'(w_st_idx)]};
  assign w_st_last = !w_st_match && w_st_final &&
                     (w_st_cnt == 2'd1);

  assign w_done = bus.tok_rdy &&
                  ((r_state == EMIT_DIST) ||
                   (r_state == EMIT_LIT && r_lit_cnt <= 2'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      for (int i = 0; i < WIN; i++)
        r_hist[i] <= '0;
      r_fill     <= '0;
      r_len      <= '0;
      r_mask     <= '0;
      r_tok_vld  <= 1'b0;
      r_tok_data <= '0;
      r_tok_ext  <= '0;
      r_tok_last <= 1'b0;
      r_dq       <= '0;
      r_lit_idx  <= '0;
      r_lit_cnt  <= '0;
      r_final    <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      if (w_acc) begin
        for (int i = 0; i < WIN; i++)
          r_hist[i] <= w_nhist[i];
        if (r_fill != FW'(WIN))
          r_fill <= r_fill + 1'b1;
        r_len  <= w_nlen;
        r_mask <= w_nmask;
      end
      unique case (r_state)
        ACCUM, FLUSH_LAST: begin
          if (w_st_go) begin
            r_tok_vld  <= 1'b1;
            r_tok_data <= w_st_data;
            r_tok_ext  <= '0;
            r_tok_last <= w_st_last;
            r_dq       <= 9'(w_st_dq);
            r_lit_idx  <= w_st_idx;
            r_lit_cnt  <= w_st_cnt;
            r_final    <= w_st_final;
            r_pend     <= w_st_pend;
            r_state    <= w_st_match ? EMIT_LEN : EMIT_LIT;
          end
        end
        EMIT_LEN: begin
          if (bus.tok_rdy) begin
            r_tok_data <= {2'b00, r_dq[8:6]};
            r_tok_ext  <= r_dq[5:0];
            r_tok_last <= r_final;
            r_state    <= EMIT_DIST;
          end
        end
        EMIT_DIST: begin
        end
        EMIT_LIT: begin
          if (bus.tok_rdy && r_lit_cnt > 2'd1) begin
            r_lit_idx  <= r_lit_idx - 2'd1;
            r_lit_cnt  <= r_lit_cnt - 2'd1;
            r_tok_data <= {1'b0, r_hist[IW'(r_lit_idx - 2'd1)]};
            r_tok_last <= r_final && (r_lit_cnt == 2'd2);
          end
        end
      endcase
      if (w_done) begin
        r_tok_vld  <= 1'b0;
        r_tok_data <= '0;
        r_tok_ext  <= '0;
        r_tok_last <= 1'b0;
        r_state    <= (!r_final && r_pend) ? FLUSH_LAST : ACCUM;
        if (r_final) begin
          for (int i = 0; i < WIN; i++)
            r_hist[i] <= '0;
          r_fill  <= '0;
          r_len   <= '0;
          r_mask  <= '0;
          r_pend  <= 1'b0;
          r_final <= 1'b0;
        end
      end
    end
  end

  assign bus.in_rdy   = (r_state == ACCUM);
  assign bus.tok_vld  = r_tok_vld;
  assign bus.tok_data = r_tok_data;
  assign bus.tok_ext  = r_tok_ext;
  assign bus.tok_last = r_tok_last;
endmodule

// File: tb/tb_lz_matcher.sv
// tb_lz_matcher: directed vectors for lz_matcher with hand-computed tokens.
// Tokens are compared as {last, data[4:0], ext[5:0]}.
module tb_lz_matcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lz_matcher_if bus();

  lz_matcher #(.WIN(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tot = 0;
  int n_bad = 0;
  int mode = 0;
  logic [11:0] q[$];
  logic got_last = 1'b0;
  logic [3:0] stim[$];
  logic [11:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin : collect
    logic prev_stall;
    logic [11:0] prev_tok;
    logic [11:0] cur;
    prev_stall = 1'b0;
    prev_tok = '0;
    forever begin
      @(negedge clk);
      case (mode)
        0: bus.tok_rdy = 1'b1;
        1: bus.tok_rdy = 1'($urandom_range(0, 1));
        default: bus.tok_rdy = 1'b0;
      endcase
      cur = {bus.tok_last, bus.tok_data, bus.tok_ext};
      if (rst_n && prev_stall)
        chk("stable", {bus.tok_vld, cur}, {1'b1, prev_tok});
      if (rst_n && bus.tok_vld && bus.tok_rdy) begin
        q.push_back(cur);
        if (cur[11]) got_last = 1'b1;
      end
      prev_stall = rst_n && bus.tok_vld && !bus.tok_rdy;
      prev_tok = cur;
    end
  end

  task automatic lit(input logic [3:0] v);
    stim.push_back(v);
  endtask

  task automatic tok(input logic l, input logic [4:0] d,
                     input logic [5:0] e);
    expq.push_back({l, d, e});
  endtask

  task automatic send_lit(input logic [3:0] v, input logic l);
    int t;
    t = 0;
    bus.in_vld = 1'b1;
    bus.in_data = v;
    bus.in_last = l;
    while (!bus.in_rdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_wait", 32'(t < 500), 1);
    @(negedge clk);
  endtask

  task automatic run(input string tag);
    int t;
    q.delete();
    got_last = 1'b0;
    foreach (stim[i])
      send_lit(stim[i], i == stim.size() - 1);
    bus.in_vld = 1'b0;
    bus.in_last = 1'b0;
    t = 0;
    while (!got_last && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ":end"}, 32'(got_last), 1);
    repeat (4) @(negedge clk);
    chk({tag, ":cnt"}, q.size(), expq.size());
    foreach (expq[i])
      chk($sformatf("%s:t%0d", tag, i),
          i < q.size() ? 32'(q[i]) : 32'hdead, 32'(expq[i]));
    stim.delete();
    expq.delete();
  endtask

  initial begin
    bus.in_vld = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.tok_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(bus.in_rdy), 1);
    chk("idle_vld", 32'(bus.tok_vld), 0);
    chk("idle_data", 32'(bus.tok_data), 0);
    chk("idle_ext", 32'(bus.tok_ext), 0);
    chk("idle_last", 32'(bus.tok_last), 0);

    lit(1); lit(2); lit(3);
    tok(0, 5'h01, 0); tok(0, 5'h02, 0); tok(1, 5'h03, 0);
    run("lit3");

    for (int i = 0; i < 5; i++) lit(4'hA);
    tok(0, 5'h0A, 0); tok(0, 5'h11, 0); tok(1, 5'h00, 0);
    run("a5");

    lit(1); lit(2); lit(3); lit(1); lit(2); lit(3); lit(7);
    tok(0, 5'h01, 0); tok(0, 5'h02, 0); tok(0, 5'h03, 0);
    tok(0, 5'h10, 0); tok(0, 5'h00, 6'h02); tok(1, 5'h07, 0);
    run("rep3");

    lit(1); lit(2); lit(3);
    tok(0, 5'h01, 0); tok(0, 5'h02, 0); tok(1, 5'h03, 0);
    run("fresh");

    for (int i = 0; i < 20; i++) lit(4'h5);
    tok(0, 5'h05, 0); tok(0, 5'h1F, 0);
    tok(0, 5'h00, 0); tok(1, 5'h05, 0);
    run("run20");

    for (int i = 0; i < 19; i++) lit(4'h5);
    tok(0, 5'h05, 0); tok(0, 5'h1F, 0); tok(1, 5'h00, 0);
    run("run19");

    for (int i = 0; i < 16; i++) begin
      lit(4'(i));
      tok(0, 5'(i), 0);
    end
    lit(0); lit(1); lit(2);
    tok(0, 5'h10, 0); tok(1, 5'h00, 6'h0F);
    run("win16");

    mode = 1;
    lit(1); lit(2); lit(3); lit(1); lit(2); lit(3); lit(7);
    tok(0, 5'h01, 0); tok(0, 5'h02, 0); tok(0, 5'h03, 0);
    tok(0, 5'h10, 0); tok(0, 5'h00, 6'h02); tok(1, 5'h07, 0);
    run("stall");

    mode = 2;
    q.delete();
    send_lit(4'hA, 1'b0);
    send_lit(4'hA, 1'b0);
    bus.in_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_vld", 32'(bus.tok_vld), 1);
    chk("pre_rst_data", 32'(bus.tok_data), 32'h0A);
    #2 rst_n = 1'b0;
    #1 chk("rst_vld", 32'(bus.tok_vld), 0);
    chk("rst_data", 32'(bus.tok_data), 0);
    mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_vld%0d", i), 32'(bus.tok_vld), 0);
    end
    chk("post_rst_q", q.size(), 0);
    chk("post_rst_rdy", 32'(bus.in_rdy), 1);

    lit(4'hA); lit(4'hA); lit(4'hA);
    tok(0, 5'h0A, 0); tok(0, 5'h0A, 0); tok(1, 5'h0A, 0);
    run("aaa");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/lz_matcher.md
LZ_MATCHER -- requirements
Module: lz_matcher

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all logic on the rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_vld  in  1  input literal valid.
REQ-004 SHALL have ports: in_data  in  4  input literal.
REQ-005 SHALL have ports: in_last  in  1  last literal of stream; qualified by in_vld.
REQ-006 SHALL have ports: in_rdy  out  1  literal accepted when in_vld & in_rdy.
REQ-007 SHALL have ports: tok_vld  out  1  token valid.
REQ-008 SHALL have ports: tok_data  out  5  token symbol, same format as the lz_extractor data_in.
REQ-009 SHALL have ports: tok_ext  out  6  token extra bits, same format as the lz_extractor ext_bits.
REQ-010 SHALL have ports: tok_last  out  1  final token of stream.
REQ-011 SHALL have ports: tok_rdy  in  1  token accepted when tok_vld & tok_rdy.
REQ-012 SHALL have parameter: WIN, default 16, history depth (maximum match distance).

Function
REQ-013 Token formats SHALL be:
- literal: tok_data={0,lit}, tok_ext=0.
- match length: tok_data={1,len-3}, len 3..18, tok_ext=0.
- match distance: always immediately after its length token; tok_data={2'b00,(dist-1)[8:6]}, tok_ext=(dist-1)[5:0].
REQ-014 History SHALL be a WIN-entry shift register with a fill counter saturating at WIN.
- hist[0] is the newest symbol.
- Each accepted literal shifts into hist[0].
REQ-015 On an accepted literal s, eq[d] (d=1..WIN) SHALL be (s==hist[d-1]) & (d<=fill), evaluated before the shift.
REQ-016 Run state SHALL be len (0..18) and mask[WIN].
- On accept, m = eq if len==0, else mask & eq.
- If m!=0 and len+1<18: len++, mask=m.
- If m!=0 and len+1==18: emit match (len 18, dist = lowest set bit of m); run cleared to len=0.
- If m==0: flush the old run, then start a new run with len=1, mask=eq.
REQ-017 Flush of a run SHALL be:
- len>=3: emit match (len, dist = lowest set bit of old mask).
- len 1..2: emit len literals taken from history, oldest first.
- len==0: emit nothing.
REQ-018 Match distance SHALL be the smallest valid distance. Overlapping matches (dist<len) are legal.
REQ-019 When the accepted literal has in_last=1, it SHALL be processed per REQ-016, then the run it leaves SHALL be flushed. tok_last=1 on the final token emitted.
REQ-020 FSM states SHALL be ACCUM, EMIT_LEN, EMIT_DIST, EMIT_LIT, FLUSH_LAST.
- in_rdy=1 only in ACCUM.
- Each emit state holds until tok_rdy.
- Emission returns to ACCUM, or to FLUSH_LAST when in_last is pending.
REQ-021 Tokens SHALL be registered; the first token of an emission appears the cycle after the triggering accept.
REQ-022 tok_vld/tok_data/tok_ext/tok_last SHALL stay stable while tok_vld & !tok_rdy.
REQ-023 After the tok_last token is accepted, history, fill and run SHALL clear; the next stream starts with an empty window.
REQ-024 Greedy only: no lazy matching and no rescan of flushed literals.

Reset
REQ-025 Asynchronous rst_n low SHALL force:
- state=ACCUM, len=0, mask=0, fill=0, history=0.
- tok_vld=0, tok_data=0, tok_ext=0, tok_last=0.
- in_rdy=1 once released.
REQ-026 Reset asserted mid-emission SHALL discard the pending tokens; no token SHALL appear after release until new input arrives.

Verification
REQ-027 Reset release, idle -> in_rdy=1, tok_vld=0, all tok_* outputs 0.
REQ-028 Literals 1,2,3(last) -> tokens 0x01, 0x02, 0x03; tok_last only on 0x03.
REQ-029 A,A,A,A,A(last) -> literal 0x0A, then length 0x11, then distance tok_data=0x00 tok_ext=0 with tok_last=1.
REQ-030 1,2,3,1,2,3,7(last) -> tokens:
- literals 0x01, 0x02, 0x03;
- length 0x10;
- distance tok_data=0x00, tok_ext=0x02;
- literal 0x07 with tok_last=1.
REQ-031 Twenty 0x5 literals, last on the 20th -> literal 0x05; length 0x1F; distance 0x00/0; literal 0x05 with tok_last=1.
REQ-032 REQ-030 stimulus with tok_rdy randomly low 50% -> identical token sequence, outputs stable while stalled, no literal accepted outside ACCUM.
